instruction_fetch: RTL and testbench

Fetch stage between the program counter and decode in the RV32 core. Reads the current PC, issues instruction-memory reads over a request/grant + response-valid interface, and advances the PC by pulsing its increment input on every granted request. Fetched words are buffered and presented to decode through a valid/ready handshake; a flush from execute discards all in-flight and buffered fetches when the PC is redirected.

---
 rtl/instruction_fetch_pkg.sv | 19 +
 rtl/instruction_fetch_fifo.sv | 70 +++++++
 rtl/instruction_fetch.sv | 112 +++++++++++
 tb/tb_instruction_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types for the fetch stage: the buffered fetch entry and the
// instruction word size.
package instruction_fetch_pkg;

  typedef logic [31:0] int32_t;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    int32_t pc;
    int32_t instr;
    logic   fault;
  } fetch_entry_t;

  function automatic logic is_aligned(input int32_t addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Small synchronous FIFO with registered storage and a combinational head.
// An occupancy count is exported so the owner can do its own flow control.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] count,
  output T                       head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  T               mem_q [DEPTH];
  T               mem_d [DEPTH];
  logic [AW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           push_ok, pop_ok;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    push_ok = push && (cnt_q != FULL_CNT);
    pop_ok  = pop && (cnt_q != '0);
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + 1'b1;
      end else begin
        wr_d = wr_q;
      end
      if (pop_ok) begin
        rd_d = rd_q + 1'b1;
      end else begin
        rd_d = rd_q;
      end
      cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues instruction-memory reads at the current PC, buffers
// returned words for decode and discards in-flight fetches on a redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_increment,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [0:0] STATE_RUN   = 1'b0;
  localparam logic [0:0] STATE_FAULT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] aq_count, buf_count, occ, o_next;
  int32_t        aq_head;
  fetch_entry_t  buf_head, buf_in;
  logic          in_run, aligned, fault_push, rsp_keep, buf_push, buf_pop;

  // The address queue length is the outstanding-request count.
  fetch_fifo #(.DEPTH(DEPTH), .T(int32_t)) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .push      (pc_increment),
    .push_data (pc),
    .pop       (mem_rvalid),
    .clear     (1'b0),
    .count     (aq_count),
    .head      (aq_head)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_instr_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (buf_pop),
    .clear     (flush),
    .count     (buf_count),
    .head      (buf_head)
  );

  always_comb begin
    in_run       = (state_q == STATE_RUN);
    aligned      = is_aligned(pc);
    occ          = aq_count + buf_count;
    mem_req      = !rst && in_run && !flush && aligned && (occ < DEPTH_C);
    pc_increment = mem_req && mem_gnt;
    // A misaligned PC is reported only once the pipe ahead of it is empty.
    fault_push   = !rst && in_run && !flush && !aligned &&
                   (aq_count == '0) && (buf_count < DEPTH_C);
    rsp_keep     = mem_rvalid && (disc_q == '0) && !flush;
    buf_push     = rsp_keep || fault_push;
    if (fault_push) begin
      buf_in = '{pc: pc, instr: 32'h0000_0000, fault: 1'b1};
    end else begin
      buf_in = '{pc: aq_head, instr: mem_rdata, fault: 1'b0};
    end
    instr_valid  = !rst && (buf_count != '0) && !flush;
    buf_pop      = instr_valid && instr_ready;
    o_next       = aq_count + {{(CW-1){1'b0}}, pc_increment}
                            - {{(CW-1){1'b0}}, mem_rvalid};
    if (flush) begin
      disc_d = o_next;
    end else if (mem_rvalid && (disc_q != '0)) begin
      disc_d = disc_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      disc_d = disc_q;
    end
    if (flush) begin
      state_d = STATE_RUN;
    end else if (fault_push) begin
      state_d = STATE_FAULT;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_RUN;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
    end
  end

  assign mem_addr    = pc;
  assign instr       = buf_head.instr;
  assign instr_pc    = buf_head.pc;
  assign instr_fault = buf_head.fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural PC, an in-order
// instruction memory of configurable latency and an expected-entry scoreboard.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        flush = 1'b0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        instr_ready = 1'b0;
  logic        pc_increment, mem_req, instr_valid, instr_fault;
  logic [31:0] mem_addr, instr, instr_pc;

  always #5 clk = ~clk;

  instruction_fetch #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_increment (pc_increment),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_fault  (instr_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t        pend[$];
  fetch_entry_t exp_q[$];

  int          cyc = 0;
  int          lat = 1;
  int          n_total = 0;
  int          n_pass = 0;
  int          n_grant, n_pop, n_req, n_valid;
  int          first_req_cyc, first_valid_cyc, rel_cyc;
  bit          first_pop_seen;
  logic [31:0] first_pop_pc, last_grant, pc_next, flush_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic clear_stats();
    n_grant = 0; n_pop = 0; n_req = 0; n_valid = 0;
    first_req_cyc = -1; first_valid_cyc = -1;
    first_pop_seen = 1'b0; first_pop_pc = 32'hDEAD_BEEF;
  endtask

  // One clock: observe at the falling edge, update environment after the rising edge.
  task automatic tick();
    fetch_entry_t e;
    pend_t        p;
    @(negedge clk);
    pc_next = pc;
    if (!rst) begin
      if (mem_req) begin
        n_req++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (instr_valid) begin
        n_valid++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (instr_valid && instr_ready) begin
        n_pop++;
        if (!first_pop_seen) begin
          first_pop_seen = 1'b1;
          first_pop_pc   = instr_pc;
        end
        if (exp_q.size() == 0) begin
          chk("pop_has_expected", 32'(instr_pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("instr", instr, e.instr);
          chk("instr_pc", instr_pc, e.pc);
          chk("instr_fault", 32'(instr_fault), 32'(e.fault));
        end
      end
      if (mem_rvalid && pend.size() != 0) begin
        p = pend.pop_front();
        if (!p.stale && !flush)
          exp_q.push_back('{pc: p.addr, instr: memword(p.addr), fault: 1'b0});
      end
      if (flush) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_q.delete();
        pc_next = flush_pc;
      end else if (pc_increment) begin
        pc_next = pc + 32'd4;
      end
      if (mem_req && mem_gnt) begin
        n_grant++;
        last_grant = pc;
        pend.push_back('{addr: pc, due: cyc + lat, stale: 1'b0});
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (!rst) begin
      pc    = pc_next;
      flush = 1'b0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memword(pend[0].addr);
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
      end
    end
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b1; flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; pc = 32'h0;
    pend.delete();
    exp_q.delete();
    @(posedge clk); cyc++;
    #1;
    if (check) begin
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_pc_increment", 32'(pc_increment), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_instr_fault", 32'(instr_fault), 32'd0);
    end
    @(posedge clk); cyc++;
    #1;
    rst = 1'b0;
    rel_cyc = cyc;
    clear_stats();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Streaming: 1-cycle memory, grant and ready held high.
    mem_gnt = 1'b1; instr_ready = 1'b1; lat = 1;
    do_reset(1'b1);
    repeat (12) tick();
    chk("first_req_cycle", 32'(first_req_cyc), 32'(rel_cyc));
    chk("first_valid_cycle", 32'(first_valid_cyc), 32'(rel_cyc + 2));
    chk("stream_grants", 32'(n_grant), 32'd12);
    chk("stream_pops", 32'(n_pop), 32'd10);
    chk("stream_first_pc", first_pop_pc, 32'h0);

    // Decode stalled from reset: buffer fills to DEPTH, then drains in order.
    instr_ready = 1'b0;
    do_reset(1'b0);
    repeat (8) tick();
    chk("stall_grants", 32'(n_grant), 32'd4);
    #1;
    chk("stall_mem_req", 32'(mem_req), 32'd0);
    chk("stall_instr_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    clear_stats();
    repeat (6) tick();
    chk("drain_first_pc", first_pop_pc, 32'h0);
    chk("drain_pops_ge4", 32'(n_pop >= 4), 32'd1);

    // Redirect one cycle after the grant of 0x8 with 2-cycle memory.
    lat = 2;
    do_reset(1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (n_grant >= 3 && last_grant == 32'h8) found = 1'b1;
    end
    chk("grant_0x8_seen", 32'(found), 32'd1);
    flush = 1'b1; flush_pc = 32'h100;
    #1;
    chk("flush_no_req", 32'(mem_req), 32'd0);
    chk("flush_no_valid", 32'(instr_valid), 32'd0);
    tick();
    clear_stats();
    repeat (10) tick();
    chk("redirect_first_pc", first_pop_pc, 32'h100);
    chk("redirect_pops", 32'(n_pop >= 4), 32'd1);

    // Misaligned redirect: a single fault entry, then stall until the next flush.
    flush = 1'b1; flush_pc = 32'h102;
    tick();
    clear_stats();
    exp_q.push_back('{pc: 32'h102, instr: 32'h0, fault: 1'b1});
    repeat (10) tick();
    chk("fault_no_req", 32'(n_req), 32'd0);
    chk("fault_one_pop", 32'(n_pop), 32'd1);
    #1;
    chk("fault_stall_valid", 32'(instr_valid), 32'd0);

    // Grant withheld for 3 cycles after redirect out of FAULT.
    mem_gnt = 1'b0; flush = 1'b1; flush_pc = 32'h200;
    tick();
    clear_stats();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nogrant_req", 32'(mem_req), 32'd1);
      chk("nogrant_addr", mem_addr, 32'h200);
      chk("nogrant_inc", 32'(pc_increment), 32'd0);
      tick();
    end
    mem_gnt = 1'b1;
    repeat (10) tick();
    chk("resume_first_pc", first_pop_pc, 32'h200);
    chk("resume_pops", 32'(n_pop >= 3), 32'd1);

    // Reset with two outstanding and two buffered entries.
    instr_ready = 1'b0; lat = 2;
    do_reset(1'b0);
    repeat (4) tick();
    chk("prerst_valid", 32'(instr_valid), 32'd1);
    rst = 1'b1; mem_rvalid = 1'b0;
    #1;
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_req", 32'(mem_req), 32'd0);
    instr_ready = 1'b1; lat = 1;
    do_reset(1'b0);
    repeat (8) tick();
    chk("restart_first_pc", first_pop_pc, 32'h0);
    chk("restart_pops", 32'(n_pop), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
